// File: rtl/operand_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg  (shared CPU package, lives with operand_fetch)
//  Description : Register-file-wide constants and types shared by the
//                operand fetch stage, its interface and its operand slots.
//                Also provides the writeback forwarding match helper.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_pkg;

    localparam int REG_ADDR_W     = 5;
    localparam int DEFAULT_DATA_W = 64;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // X31 reads as zero and is never a forwarding target.
    localparam reg_addr_t XZR = 5'd31;

    // True when a writeback to wbAddr must replace the value read for src.
    function automatic logic fwdHit(input logic      wbEn,
                                    input reg_addr_t wbAddr,
                                    input reg_addr_t src);
        return wbEn && (wbAddr == src) && (src != XZR);
    endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/operand_fetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : operand_fetch_if
//  Description : Bundle of every non-clock connection of operand_fetch:
//                upstream request handshake, register file read port,
//                writeback snoop bus and downstream operand handshake.
//  Modports    : slave  - the operand fetch stage itself
//                master - the surrounding pipeline / register file
//  Revision    : 1.0  initial release
// ============================================================================
interface operand_fetch_if
    import cpu_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CTRL_W = 32
) ();

    // Upstream request
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    reg_addr_t         in_rn;
    reg_addr_t         in_rm;
    logic [CTRL_W-1:0] in_ctrl;

    // Register file read port (data arrives one cycle after the address)
    reg_addr_t         RegAddr1;
    reg_addr_t         RegAddr2;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;

    // Writeback bus, identical to the register file write port
    logic              wb_en;
    reg_addr_t         wb_addr;
    logic [DATA_W-1:0] wb_data;

    // Downstream operands
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_op1;
    logic [DATA_W-1:0] out_op2;
    logic [CTRL_W-1:0] out_ctrl;
    reg_addr_t         out_rn;
    reg_addr_t         out_rm;

    modport slave (
        input  flush, in_valid, in_rn, in_rm, in_ctrl,
        input  ReadData1, ReadData2,
        input  wb_en, wb_addr, wb_data,
        input  out_ready,
        output in_ready, RegAddr1, RegAddr2,
        output out_valid, out_op1, out_op2, out_ctrl, out_rn, out_rm
    );

    modport master (
        output flush, in_valid, in_rn, in_rm, in_ctrl,
        output ReadData1, ReadData2,
        output wb_en, wb_addr, wb_data,
        output out_ready,
        input  in_ready, RegAddr1, RegAddr2,
        input  out_valid, out_op1, out_op2, out_ctrl, out_rn, out_rm
    );

endinterface : operand_fetch_if
`default_nettype wire

// File: rtl/operand_fetch_slot.sv
`default_nettype none
// ============================================================================
//  Module      : operand_slot
//  Description : One source operand of the operand fetch stage: same-edge
//                bypass flag/data, stall hold register with writeback snoop,
//                and the X31-zeroing output mux.
//  Config      : OPERAND_FETCH_BYPASS_EN - when undefined, bypass and snoop
//                are disabled and the operand is the raw register file value.
//  Ports       : clk, reset      clock, synchronous active-high reset
//                i_accept        new entry captured at this edge
//                i_stallHold     entry held and not transferring this edge
//                i_fresh         i_readData belongs to the held entry
//                i_srcIn         source index of the incoming request
//                i_srcHeld       source index of the held entry
//                i_wbEn/Addr/Data writeback bus
//                i_readData      registered register file data
//                o_op            operand presented to execute
//  Revision    : 1.0  initial release
// ============================================================================
module operand_slot
    import cpu_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_accept,
    input  logic              i_stallHold,
    input  logic              i_fresh,
    input  reg_addr_t         i_srcIn,
    input  reg_addr_t         i_srcHeld,
    input  logic              i_wbEn,
    input  reg_addr_t         i_wbAddr,
    input  logic [DATA_W-1:0] i_wbData,
    input  logic [DATA_W-1:0] i_readData,
    output logic [DATA_W-1:0] o_op
);

    logic              r_byp;
    logic [DATA_W-1:0] r_bypData;
    logic [DATA_W-1:0] r_hold;
    logic              w_bypHit;
    logic              w_snoopHit;

`ifdef OPERAND_FETCH_BYPASS_EN
    // The register file returns the pre-write value when a write and a read
    // of the same register share an edge, so that write is captured here.
    assign w_bypHit   = fwdHit(i_wbEn, i_wbAddr, i_srcIn);
    // While stalled, later writes to the held source must update the hold.
    assign w_snoopHit = fwdHit(i_wbEn, i_wbAddr, i_srcHeld);
`else
    logic w_unusedWb;
    assign w_bypHit   = 1'b0;
    assign w_snoopHit = 1'b0;
    assign w_unusedWb = ^{i_wbEn, i_wbAddr, i_srcIn};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_byp     <= 1'b0;
            r_bypData <= '0;
            r_hold    <= '0;
        end else begin
            if (i_accept) begin
                r_byp     <= w_bypHit;
                r_bypData <= i_wbData;
            end
            // Hold tracks the presented operand on every stalled edge so the
            // value stays correct once ReadData moves on.
            if (i_stallHold) begin
                r_hold <= w_snoopHit ? i_wbData : o_op;
            end
        end
    end

    always_comb begin
        o_op = '0;
        if (i_srcHeld == XZR) begin
            o_op = '0;
        end else if (i_fresh) begin
            o_op = r_byp ? r_bypData : i_readData;
        end else begin
            o_op = r_hold;
        end
    end

endmodule : operand_slot
`default_nettype wire

// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : operand_fetch
//  Description : Decode-to-execute operand fetch stage behind a 32x64
//                register file with registered read data. Holds one entry
//                under valid/ready, drives the read addresses, forwards
//                same-edge and in-stall writebacks and zeroes X31 operands.
//                Accept at edge E, operands valid during cycle E+1,
//                one entry per cycle throughput.
//  Config      : OPERAND_FETCH_BYPASS_EN enables writeback forwarding
//                (default: disabled, raw register file operands).
//  Ports       : clk    clock
//                reset  synchronous active-high reset
//                bus    operand_fetch_if.slave (request, regfile read port,
//                       writeback bus, operand output handshake)
//  Revision    : 1.0  initial release
// ============================================================================
module operand_fetch
    import cpu_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CTRL_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    operand_fetch_if.slave  bus
);

    logic              r_outValid;
    logic              r_fresh;
    logic [CTRL_W-1:0] r_outCtrl;
    reg_addr_t         r_outRn;
    reg_addr_t         r_outRm;

    logic              w_inReady;
    logic              w_accept;
    logic              w_transfer;
    logic              w_stallHold;
    logic [DATA_W-1:0] w_op1;
    logic [DATA_W-1:0] w_op2;

    assign w_inReady   = !bus.flush && (!r_outValid || bus.out_ready);
    assign w_accept    = bus.in_valid && w_inReady;
    assign w_transfer  = r_outValid && bus.out_ready;
    assign w_stallHold = r_outValid && !w_transfer;

    // Idle cycles keep re-reading the held sources; harmless and keeps the
    // address stable for the register file.
    assign bus.RegAddr1 = w_accept ? bus.in_rn : r_outRn;
    assign bus.RegAddr2 = w_accept ? bus.in_rm : r_outRm;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_outValid <= 1'b0;
            r_fresh    <= 1'b0;
            r_outCtrl  <= '0;
            r_outRn    <= '0;
            r_outRm    <= '0;
        end else begin
            // ReadData only belongs to the entry in the cycle after accept.
            r_fresh <= w_accept;
            if (bus.flush) begin
                r_outValid <= 1'b0;
            end else if (w_accept) begin
                r_outValid <= 1'b1;
                r_outCtrl  <= bus.in_ctrl;
                r_outRn    <= bus.in_rn;
                r_outRm    <= bus.in_rm;
            end else if (w_transfer) begin
                r_outValid <= 1'b0;
            end
        end
    end

    operand_slot #(.DATA_W(DATA_W)) u_slot1 (
        .clk         (clk),
        .reset       (reset),
        .i_accept    (w_accept),
        .i_stallHold (w_stallHold),
        .i_fresh     (r_fresh),
        .i_srcIn     (bus.in_rn),
        .i_srcHeld   (r_outRn),
        .i_wbEn      (bus.wb_en),
        .i_wbAddr    (bus.wb_addr),
        .i_wbData    (bus.wb_data),
        .i_readData  (bus.ReadData1),
        .o_op        (w_op1)
    );

    operand_slot #(.DATA_W(DATA_W)) u_slot2 (
        .clk         (clk),
        .reset       (reset),
        .i_accept    (w_accept),
        .i_stallHold (w_stallHold),
        .i_fresh     (r_fresh),
        .i_srcIn     (bus.in_rm),
        .i_srcHeld   (r_outRm),
        .i_wbEn      (bus.wb_en),
        .i_wbAddr    (bus.wb_addr),
        .i_wbData    (bus.wb_data),
        .i_readData  (bus.ReadData2),
        .o_op        (w_op2)
    );

    assign bus.in_ready  = w_inReady;
    assign bus.out_valid = r_outValid;
    assign bus.out_op1   = w_op1;
    assign bus.out_op2   = w_op2;
    assign bus.out_ctrl  = r_outCtrl;
    assign bus.out_rn    = r_outRn;
    assign bus.out_rm    = r_outRm;

endmodule : operand_fetch
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_operand_fetch
//  Description : Directed scoreboard bench for operand_fetch with a
//                behavioural 32x64 register file (registered read data,
//                write-then-read returns the old value on the same edge).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_operand_fetch;
    import cpu_pkg::*;

    localparam int DATA_W = 64;
    localparam int CTRL_W = 32;
`ifdef OPERAND_FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic [CTRL_W-1:0] ctrl;
        logic [4:0]        rn;
        logic [4:0]        rm;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    exp_t q[$];
    exp_t monE;
    logic [DATA_W-1:0] rf [32];
    logic [DATA_W-1:0] expStall;

    always #5 clk = ~clk;

    operand_fetch_if #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus ();

    operand_fetch #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Register file model: registered reads, old data on same-edge write.
    always @(posedge clk) begin
        bus.ReadData1 <= rf[bus.RegAddr1];
        bus.ReadData2 <= rf[bus.RegAddr2];
        if (bus.wb_en) rf[bus.wb_addr] <= bus.wb_data;
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [DATA_W-1:0] d);
        bus.wb_en   = 1'b1;
        bus.wb_addr = a;
        bus.wb_data = d;
        step();
        bus.wb_en   = 1'b0;
    endtask

    // Present one request for one edge; optionally queue its expected result.
    task automatic issue(input logic [4:0] rn, input logic [4:0] rm, input logic [CTRL_W-1:0] ctrl,
                         input logic [DATA_W-1:0] e1, input logic [DATA_W-1:0] e2, input bit push);
        exp_t e;
        bus.in_valid = 1'b1;
        bus.in_rn    = rn;
        bus.in_rm    = rm;
        bus.in_ctrl  = ctrl;
        @(negedge clk);
        chk("in_ready", bus.in_ready, 1'b1);
        chk("RegAddr1", bus.RegAddr1, rn);
        chk("RegAddr2", bus.RegAddr2, rm);
        if (push) begin
            e.op1 = e1; e.op2 = e2; e.ctrl = ctrl; e.rn = rn; e.rm = rm;
            q.push_back(e);
        end
        step();
        bus.in_valid = 1'b0;
    endtask

    // Monitor: every output transfer is matched against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL xfer unexpected op1=%0h op2=%0h exp=none", bus.out_op1, bus.out_op2);
                end else begin
                    monE = q.pop_front();
                    chk("xfer", {bus.out_op1, bus.out_op2, bus.out_ctrl, bus.out_rn, bus.out_rm},
                                {monE.op1, monE.op2, monE.ctrl, monE.rn, monE.rm});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_rn     = 5'd5;
        bus.in_rm     = 5'd7;
        bus.in_ctrl   = '1;
        bus.wb_en     = 1'b0;
        bus.wb_addr   = '0;
        bus.wb_data   = '0;
        bus.out_ready = 1'b1;

        // Reset wins over a simultaneous request.
        repeat (3) step();
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("rst_valid", bus.out_valid, 1'b0);
        chk("rst_op1",   bus.out_op1, 64'h0);
        chk("rst_op2",   bus.out_op2, 64'h0);
        chk("rst_ctrl",  bus.out_ctrl, 32'h0);
        chk("rst_rn",    bus.out_rn, 5'd0);
        chk("rst_rm",    bus.out_rm, 5'd0);
        chk("rst_ready", bus.in_ready, 1'b1);
        step();

        // Preload; X31 holds garbage so zeroing is observable.
        wr(5'd5,  64'h55);
        wr(5'd7,  64'h1);
        wr(5'd9,  64'h9);
        wr(5'd3,  64'h33);
        wr(5'd4,  64'h44);
        wr(5'd31, 64'h31);
        step();

        // Basic read with X31 on rm.
        issue(5'd5, 5'd31, 32'hA5A5_0001, 64'h55, 64'h0, 1'b1);
        step();

        // Back-to-back accepts.
        issue(5'd3, 5'd4, 32'h0000_0002, 64'h33, 64'h44, 1'b1);
        issue(5'd4, 5'd3, 32'h0000_0003, 64'h44, 64'h33, 1'b1);
        step();

        // Same-edge write to rn (old X7 = 0x1).
        bus.wb_en   = 1'b1;
        bus.wb_addr = 5'd7;
        bus.wb_data = 64'hDEAD;
        issue(5'd7, 5'd5, 32'h0000_0004, BYP ? 64'hDEAD : 64'h1, 64'h55, 1'b1);
        bus.wb_en = 1'b0;
        step();

        // Stall with writeback snoop on held rm=9, then X31 write on held rn=31.
        expStall      = BYP ? 64'hBEEF : 64'h9;
        bus.out_ready = 1'b0;
        issue(5'd31, 5'd9, 32'h0000_0005, 64'h0, expStall, 1'b1);
        bus.wb_en   = 1'b1;
        bus.wb_addr = 5'd9;
        bus.wb_data = 64'hBEEF;
        @(negedge clk);
        chk("stall0_ready", bus.in_ready, 1'b0);
        chk("stall0_op2",   bus.out_op2, 64'h9);
        step();
        bus.wb_addr = 5'd31;
        bus.wb_data = 64'hA0;
        @(negedge clk);
        chk("stall1_ready", bus.in_ready, 1'b0);
        chk("stall1_op2",   bus.out_op2, expStall);
        step();
        bus.wb_en = 1'b0;
        @(negedge clk);
        chk("stall2_ready", bus.in_ready, 1'b0);
        chk("stall2_op2",   bus.out_op2, expStall);
        chk("x31_op1",      bus.out_op1, 64'h0);
        step();
        bus.out_ready = 1'b1;
        step();
        @(negedge clk);
        chk("drain_valid", bus.out_valid, 1'b0);
        step();

        // Flush mid-stall with a competing request.
        bus.out_ready = 1'b0;
        issue(5'd5, 5'd7, 32'h0000_0006, 64'h0, 64'h0, 1'b0);
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_rn    = 5'd3;
        bus.in_rm    = 5'd4;
        @(negedge clk);
        chk("flush_ready", bus.in_ready, 1'b0);
        step();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("flush_valid", bus.out_valid, 1'b0);
        bus.out_ready = 1'b1;
        step();

        // Reset while an entry is held.
        bus.out_ready = 1'b0;
        issue(5'd3, 5'd4, 32'h0000_0077, 64'h0, 64'h0, 1'b0);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        chk("mrst_valid", bus.out_valid, 1'b0);
        chk("mrst_op1",   bus.out_op1, 64'h0);
        chk("mrst_op2",   bus.out_op2, 64'h0);
        chk("mrst_ctrl",  bus.out_ctrl, 32'h0);
        chk("mrst_rn",    bus.out_rn, 5'd0);
        chk("mrst_rm",    bus.out_rm, 5'd0);
        bus.out_ready = 1'b1;
        step();

        // Normal operation after reset.
        issue(5'd4, 5'd5, 32'h0000_0008, 64'h44, 64'h55, 1'b1);
        step();
        step();

        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_operand_fetch
`default_nettype wire
